// File: rtl/accel_pkg.sv
// Shared encodings for the convolution accelerator frame sequencer:
// FSM states, shared image BRAM ownership codes and the default watchdog limit.
package accel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLR     = 3'd1,
      ST_LOAD_K  = 3'd2,
      ST_LOAD_I  = 3'd3,
      ST_COMPUTE = 3'd4,
      ST_READOUT = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_ILOAD = 2'd1,
      OWN_CONV  = 2'd2,
      OWN_READ  = 2'd3
   } bram_owner_e;

   localparam logic [31:0] DEFAULT_TIMEOUT_CYCLES = 32'd500_000_000;

   function automatic logic is_phase_state(input state_e s);
      case (s)
         ST_LOAD_K, ST_LOAD_I, ST_COMPUTE, ST_READOUT: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

   function automatic bram_owner_e owner_for(input state_e s);
      case (s)
         ST_LOAD_I:  return OWN_ILOAD;
         ST_COMPUTE: return OWN_CONV;
         ST_READOUT: return OWN_READ;
         default:    return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Loadable phase watchdog: counts enabled cycles since the last clear and flags
// expiry when the count reaches limit-1; a limit of zero disables expiry.
module phase_watchdog #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expire
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // next count: clear wins over increment
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q;
      end
   end

   // count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = enable && (limit != '0) && (count_q == (limit - ONE));

endmodule

// File: rtl/accel_frame_sequencer.sv
// Frame phase controller: clear, kernel load, image load, convolution and
// readout, with per-phase watchdog, abort handling and shared BRAM ownership.
module accel_frame_sequencer
   import accel_pkg::*;
#(
   parameter int                   TIMEOUT_W      = 32,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(DEFAULT_TIMEOUT_CYCLES),
   parameter int                   FRAME_CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic                   keep_kernel,
   input  logic                   abort,
   input  logic                   kload_done,
   input  logic                   iload_done,
   input  logic                   conv_done,
   input  logic                   read_done,
   output logic                   kload_start,
   output logic                   iload_start,
   output logic                   conv_start,
   output logic                   read_start,
   output logic                   eng_clear,
   output logic [1:0]             bram_owner,
   output logic [2:0]             phase,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   error,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   state_e state_q, state_d;
   logic   first_q, first_d;
   logic   skip_q, skip_d;
   logic   aborted_q, aborted_d;
   logic   kernel_valid_q, kernel_valid_d;
   logic   error_q, error_d;

   logic                   kload_start_q, kload_start_d;
   logic                   iload_start_q, iload_start_d;
   logic                   conv_start_q, conv_start_d;
   logic                   read_start_q, read_start_d;
   logic                   eng_clear_q, eng_clear_d;
   logic [1:0]             bram_owner_q, bram_owner_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

   logic   eng_done_s;
   state_e next_phase_s;
   logic   entering_s;
   logic   wd_expire_s;

   assign entering_s = (state_d != state_q);

   phase_watchdog #(
      .W (TIMEOUT_W)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (entering_s),
      .enable (is_phase_state(state_q)),
      .limit  (TIMEOUT_CYCLES),
      .expire (wd_expire_s)
   );

   // done flag and successor of the current phase state
   always_comb begin
      eng_done_s   = 1'b0;
      next_phase_s = ST_IDLE;
      case (state_q)
         ST_LOAD_K: begin
            eng_done_s   = kload_done;
            next_phase_s = ST_LOAD_I;
         end
         ST_LOAD_I: begin
            eng_done_s   = iload_done;
            next_phase_s = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            eng_done_s   = conv_done;
            next_phase_s = ST_READOUT;
         end
         ST_READOUT: begin
            eng_done_s   = read_done;
            next_phase_s = ST_DONE;
         end
         default: begin
            eng_done_s   = 1'b0;
            next_phase_s = ST_IDLE;
         end
      endcase
   end

   // next-state logic; abort outranks done, done outranks the watchdog
   always_comb begin
      state_d        = state_q;
      skip_d         = skip_q;
      aborted_d      = aborted_q;
      kernel_valid_d = kernel_valid_q;
      error_d        = error_q;
      case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (go && !(state_q == ST_ERROR && abort)) begin
               skip_d    = keep_kernel & kernel_valid_q;
               error_d   = 1'b0;
               aborted_d = 1'b0;
               state_d   = ST_CLR;
            end else begin
               state_d = state_q;
            end
         end
         ST_CLR: begin
            if (first_q) begin
               state_d = ST_CLR;
            end else if (aborted_q) begin
               state_d = ST_IDLE;
            end else if (skip_q) begin
               state_d = ST_LOAD_I;
            end else begin
               state_d = ST_LOAD_K;
            end
         end
         ST_LOAD_K, ST_LOAD_I, ST_COMPUTE, ST_READOUT: begin
            // first cycle in a phase masks done flags left over from earlier work
            if (abort) begin
               state_d        = ST_CLR;
               aborted_d      = 1'b1;
               kernel_valid_d = (state_q == ST_LOAD_K) ? 1'b0 : kernel_valid_q;
            end else if (eng_done_s && !first_q) begin
               state_d        = next_phase_s;
               kernel_valid_d = (state_q == ST_LOAD_K) ? 1'b1 : kernel_valid_q;
            end else if (wd_expire_s) begin
               state_d        = ST_ERROR;
               error_d        = 1'b1;
               kernel_valid_d = (state_q == ST_LOAD_K) ? 1'b0 : kernel_valid_q;
            end else begin
               state_d = state_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // output values computed from the state being entered so they register on the same edge
   always_comb begin
      first_d       = entering_s;
      kload_start_d = entering_s && (state_d == ST_LOAD_K);
      iload_start_d = entering_s && (state_d == ST_LOAD_I);
      conv_start_d  = entering_s && (state_d == ST_COMPUTE);
      read_start_d  = entering_s && (state_d == ST_READOUT);
      eng_clear_d   = (state_d == ST_CLR) || (entering_s && (state_d == ST_ERROR));
      bram_owner_d  = owner_for(state_d);
      busy_d        = !((state_d == ST_IDLE) || (state_d == ST_ERROR));
      frame_done_d  = entering_s && (state_d == ST_DONE);
      if (frame_done_d) begin
         frame_count_d = frame_count_q + FRAME_CNT_W'(1);
      end else begin
         frame_count_d = frame_count_q;
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         first_q        <= 1'b0;
         skip_q         <= 1'b0;
         aborted_q      <= 1'b0;
         kernel_valid_q <= 1'b0;
         error_q        <= 1'b0;
         kload_start_q  <= 1'b0;
         iload_start_q  <= 1'b0;
         conv_start_q   <= 1'b0;
         read_start_q   <= 1'b0;
         eng_clear_q    <= 1'b0;
         bram_owner_q   <= OWN_NONE;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         first_q        <= first_d;
         skip_q         <= skip_d;
         aborted_q      <= aborted_d;
         kernel_valid_q <= kernel_valid_d;
         error_q        <= error_d;
         kload_start_q  <= kload_start_d;
         iload_start_q  <= iload_start_d;
         conv_start_q   <= conv_start_d;
         read_start_q   <= read_start_d;
         eng_clear_q    <= eng_clear_d;
         bram_owner_q   <= bram_owner_d;
         busy_q         <= busy_d;
         frame_done_q   <= frame_done_d;
         frame_count_q  <= frame_count_d;
      end
   end

   assign kload_start = kload_start_q;
   assign iload_start = iload_start_q;
   assign conv_start  = conv_start_q;
   assign read_start  = read_start_q;
   assign eng_clear   = eng_clear_q;
   assign bram_owner  = bram_owner_q;
   assign phase       = state_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign error       = error_q;
   assign frame_count = frame_count_q;

endmodule
